// File: rtl/mips_mdu_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states and iteration count.
package mips_typedef;
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;
endpackage

// File: rtl/mips_mdu_iter.sv
// Datapath for the unsigned magnitude core: one shift-add multiply or restoring-divide step per enable.
module mips_mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic                div_mode,
    input  logic [XLEN-1:0]     a_mag,
    input  logic [XLEN-1:0]     b_mag,
    output logic [2*XLEN-1:0]   acc
);
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     up;
    logic              ge;
    logic [XLEN-1:0]   rem;

    // Both modes start from {0, a}: multiplier bits shift out of the low half,
    // dividend bits shift into the partial remainder in the high half.
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        up    = acc_q[2*XLEN-1:XLEN-1];
        ge    = up >= {1'b0, b_q};
        rem   = up[XLEN-1:0] - b_q;
        if (load) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            b_d   = b_mag;
            div_d = div_mode;
        end else if (en) begin
            if (div_q)
                acc_d = ge ? {rem, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
            else
                acc_d = {sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/mips_mdu.sv
// MIPS HI/LO multiply/divide unit: control FSM, sign handling, special cases and HI/LO registers.
// state   | meaning
// MD_IDLE | ready for a request, MTHI/MTLO accepted
// MD_CALC | 32 magnitude iterations in mips_mdu_iter
// MD_FIX  | sign/special-case correction, HI/LO write
module mips_mdu
    import mips_typedef::*;
#(
    parameter int XLEN = MD_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            mthi_we,
    input  logic            mtlo_we,
    input  logic [XLEN-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    md_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    md_op_t            op;
    logic              signed_op, a_neg, b_neg, accept, iter_load, iter_en;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
    logic [2*XLEN-1:0] acc;

    assign op        = md_op_t'(req_op);
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = signed_op & req_a[XLEN-1];
    assign b_neg     = signed_op & req_b[XLEN-1];
    assign a_mag     = a_neg ? -req_a : req_a;
    assign b_mag     = b_neg ? -req_b : req_b;
    assign accept    = (state_q == MD_IDLE) && req_valid && !flush;
    assign quo       = acc[XLEN-1:0];
    assign rem       = acc[2*XLEN-1:XLEN];

    mips_mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (iter_load),
        .en       (iter_en),
        .div_mode (is_div_d),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc      (acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        iter_load = 1'b0;
        iter_en   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (mthi_we) hi_d = wr_data;
                if (mtlo_we) lo_d = wr_data;
                if (accept) begin
                    state_d   = MD_CALC;
                    cnt_d     = '0;
                    is_div_d  = (op == MD_DIV) || (op == MD_DIVU);
                    neg_d     = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    div0_d    = (req_b == '0);
                    ovf_d     = (op == MD_DIV) && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b);
                    a_raw_d   = req_a;
                    iter_load = 1'b1;
                end
            end
            MD_CALC: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    iter_en = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = neg_q ? -acc : acc;
                    end else if (div0_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else if (ovf_q) begin
                        hi_d = '0;
                        lo_d = {1'b1, {(XLEN-1){1'b0}}};
                    end else begin
                        lo_d = neg_q  ? -quo : quo;
                        hi_d = rneg_q ? -rem : rem;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = (state_q == MD_IDLE);
    assign busy      = (state_q != MD_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_mips_mdu.sv
// Randomized and directed checks of mips_mdu against an arithmetic reference model.
module tb_mips_mdu;
    import mips_typedef::*;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, mthi_we, mtlo_we;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b, wr_data;
    logic        req_ready, busy, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    mips_mdu dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .mthi_we   (mthi_we),
        .mtlo_we   (mtlo_we),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: begin p = sa * sb; return p; end
            2'd1: begin p = ua * ub; return p; end
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit with_mthi);
        int n;
        chk($sformatf("%s_rdy", tag), {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (with_mthi) begin
            mthi_we = 1'b1;
            wr_data = 32'hA5A5_0F0F;
        end
        @(negedge clk);
        req_valid = 1'b0;
        mthi_we   = 1'b0;
        chk($sformatf("%s_busy", tag), {62'd0, busy, req_ready}, 64'd2);
        if (with_mthi) chk($sformatf("%s_mthi_same_edge", tag), {32'd0, hi}, 64'hA5A5_0F0F);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_latency", tag), 64'(n), 64'd33);
        chk($sformatf("%s_result", tag), {hi, lo}, exp);
        chk($sformatf("%s_ready_in_done", tag), {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int          dones;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] hi_s, lo_s;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        req_op = 2'd0; req_a = '0; req_b = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {hi, lo}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, req_ready}, 64'd1);

        do_op("mult_neg", MD_MULT, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        do_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 1'b0);
        do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        do_op("divu", MD_DIVU, 32'h7, 32'h2, 64'h0000_0001_0000_0003, 1'b0);
        do_op("div_zero", MD_DIV, 32'h5, 32'h0, 64'h0000_0005_FFFF_FFFF, 1'b0);
        do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        do_op("mthi_accept", MD_MULTU, 32'h3, 32'h5, 64'h0000_0000_0000_000F, 1'b1);

        @(negedge clk);
        mthi_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        mthi_we = 1'b0;
        chk("mthi_idle", {32'd0, hi}, 64'h1234);
        mtlo_we = 1'b1; wr_data = 32'h5678;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mtlo_idle", {32'd0, lo}, 64'h5678);

        // Flush during CALC at cnt=10.
        hi_s = hi; lo_s = lo;
        req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd100; req_b = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {62'd0, busy, req_ready}, 64'd1);
        chk("flush_hilo", {hi, lo}, {hi_s, lo_s});
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("flush_no_done", 64'(dones), 64'd0);

        // Flush in IDLE blocks a same-edge request.
        req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_req", {63'd0, busy}, 64'd0);

        // MTLO while busy is dropped.
        lo_s = lo;
        req_valid = 1'b1; req_op = MD_MULTU; req_a = 32'd9; req_b = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        mtlo_we = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mtlo_busy", {32'd0, lo}, {32'd0, lo_s});
        dones = 0;
        while (!done && dones < 60) begin
            @(negedge clk);
            dones++;
        end
        chk("mtlo_busy_result", {hi, lo}, 64'd81);

        // Randomized operations, back-to-back from each done cycle.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 9);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = $urandom_range(0, 50);
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), rop, ra, rb, ref_mdu(rop, ra, rb), 1'b0);
        end

        // Reset in the middle of CALC clears HI/LO.
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_flags", {61'd0, busy, done, req_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
